uart_char_receiver: RTL and testbench

Serial 8N1 UART receiver that sits directly upstream of the Nios character-received PIO input. It deserialises the RX line and presents the byte on `rx_data` for the data PIO. It holds `char_received` high until software acknowledges through a PIO output strobe. It also flags framing and overrun errors for polling.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_char_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_char_receiver.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART character receiver.
package uart_rx_pkg;

    // Character width of an 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // 50 MHz system clock at 115200 baud.
    localparam int UART_CLKS_PER_BIT = 434;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit or bus inputs.
// Bus use is only safe for independent, quasi-static bits.
module sync_2ff #(
    parameter int   WIDTH       = 1,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two-stage capture; both stages come out of reset at the idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= {WIDTH{RESET_VALUE}};
            sync_reg <= {WIDTH{RESET_VALUE}};
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_char_receiver.sv
// 8N1 UART receiver feeding the character-received PIO. Holds the last good
// character and a level-sensitive "char received" flag until software acks,
// with sticky framing and overrun flags for polling.
module uart_char_receiver
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    input  logic       char_ack,
    output logic [7:0] rx_data,
    output logic       char_received,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // The IDLE edge that spots the start bit already lies one cycle past T0,
    // and the counter then starts at zero, so the half-bit terminal count is
    // two short of HALF_BIT. Full bit periods run 0..CLKS_PER_BIT-1.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 2);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [2:0]                idx_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] data_reg;
    logic                      char_received_reg;
    logic                      framing_error_reg;
    logic                      overrun_error_reg;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_serial),
        .q       (rx_s)
    );

    // Frame FSM with the shared counter, shift register and output flags.
    // The ack clear is written first so a stop-sample update later in the
    // same cycle takes precedence over it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            idx_reg           <= '0;
            shift_reg         <= '0;
            data_reg          <= '0;
            char_received_reg <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_error_reg <= 1'b0;
        end else begin
            if (char_ack) begin
                char_received_reg <= 1'b0;
                framing_error_reg <= 1'b0;
                overrun_error_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_reg   <= '0;
                        state_reg <= START;
                    end
                end

                START: begin
                    if (cnt_reg == START_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            // Line back high at mid start bit: a glitch.
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= '0;
                            state_reg <= DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            data_reg          <= shift_reg;
                            char_received_reg <= 1'b1;
                            // An ack in this cycle consumes the old character.
                            if (char_received_reg && !char_ack) begin
                                overrun_error_reg <= 1'b1;
                            end
                            state_reg <= IDLE;
                        end else begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start.
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rx_data       = data_reg;
    assign char_received = char_received_reg;
    assign framing_error = framing_error_reg;
    assign overrun_error = overrun_error_reg;

endmodule

// File: tb/tb_uart_char_receiver.sv
// Scoreboard bench for uart_char_receiver at 8 clocks per bit.
module tb_uart_char_receiver;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;   // falling edge to flag update

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       rx_serial = 1'b1;
    logic       char_ack  = 1'b0;
    logic [7:0] rx_data;
    logic       char_received;
    logic       framing_error;
    logic       overrun_error;

    uart_char_receiver #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HALF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_serial     (rx_serial),
        .char_ack      (char_ack),
        .rx_data       (rx_data),
        .char_received (char_received),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
        logic        cr;
        logic        fe;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the visible register state.
    logic [7:0] m_data = 8'h00;
    logic       m_cr   = 1'b0;
    logic       m_fe   = 1'b0;
    logic       m_ov   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, expv, cyc);
        end
    endtask

    // Apply a new model state; queue an expectation only if something visible changes.
    task automatic model_set(input int unsigned due, input logic [7:0] d,
                             input logic cr, input logic fe, input logic ov);
        exp_t e;
        if (d != m_data || cr != m_cr || fe != m_fe || ov != m_ov) begin
            e.due  = due;
            e.data = d;
            e.cr   = cr;
            e.fe   = fe;
            e.ov   = ov;
            exp_q.push_back(e);
        end
        m_data = d;
        m_cr   = cr;
        m_fe   = fe;
        m_ov   = ov;
    endtask

    // Monitor: every output change must match the head of the queue, on time.
    initial begin
        logic [10:0] prev;
        logic [10:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {rx_data, char_received, framing_error, overrun_error};
            if (!reset_n) begin
                prev = cur;
                continue;
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_update actual=none expected=data%0h/cr%0d/fe%0d/ov%0d due=%0d now=%0d",
                         e.data, e.cr, e.fe, e.ov, e.due, cyc);
            end
            if (cur != prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update actual=%0h expected=%0h cycle=%0d", cur, prev, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn cycle=%0d data=%02h cr=%0d fe=%0d ov=%0d", cyc,
                             rx_data, char_received, framing_error, overrun_error);
                    cmp("update_cycle",  int'(cyc),           int'(e.due));
                    cmp("rx_data",       int'(rx_data),       int'(e.data));
                    cmp("char_received", int'(char_received), int'(e.cr));
                    cmp("framing_error", int'(framing_error), int'(e.fe));
                    cmp("overrun_error", int'(overrun_error), int'(e.ov));
                end
                prev = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one full frame from the current aligned point (#1 after an edge).
    task automatic send_frame(input logic [7:0] b, input bit good_stop,
                              input bit ack_at_stop, input int extra_low);
        int unsigned n;
        int          ackj;
        logic [7:0]  d;
        logic        cr, fe, ov;
        n    = cyc;
        ackj = LAT - 9 * CPB - 1;
        for (int k = 0; k < 9; k++) begin
            rx_serial = (k == 0) ? 1'b0 : b[k-1];
            tick(CPB);
        end
        if (good_stop) begin
            d  = b;
            cr = 1'b1;
            fe = ack_at_stop ? 1'b0 : m_fe;
            ov = ack_at_stop ? 1'b0 : (m_ov | m_cr);
        end else begin
            d  = m_data;
            cr = ack_at_stop ? 1'b0 : m_cr;
            fe = 1'b1;
            ov = ack_at_stop ? 1'b0 : m_ov;
        end
        model_set(n + LAT, d, cr, fe, ov);
        rx_serial = good_stop;
        for (int j = 0; j < CPB; j++) begin
            if (ack_at_stop && j == ackj)     char_ack = 1'b1;
            if (ack_at_stop && j == ackj + 1) char_ack = 1'b0;
            tick(1);
        end
        if (!good_stop) begin
            tick(extra_low);
            rx_serial = 1'b1;
            tick(1);
        end
    endtask

    task automatic pulse_ack();
        char_ack = 1'b1;
        model_set(cyc + 1, m_data, 1'b0, 1'b0, 1'b0);
        tick(1);
        char_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cbyte;
        tick(3);
        cmp("reset_rx_data",       int'(rx_data),       0);
        cmp("reset_char_received", int'(char_received), 0);
        cmp("reset_framing_error", int'(framing_error), 0);
        cmp("reset_overrun_error", int'(overrun_error), 0);
        reset_n = 1'b1;
        tick(4);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        tick(3);
        pulse_ack();
        tick(3);
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        tick(3);
        pulse_ack();
        tick(3);

        rx_serial = 1'b0;
        tick(2);
        rx_serial = 1'b1;
        tick(20);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        tick(3);
        pulse_ack();
        tick(3);

        send_frame(8'h55, 1'b0, 1'b0, 40);
        tick(5);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        tick(3);

        send_frame(8'h7E, 1'b1, 1'b1, 0);
        tick(3);

        // Abort 0xC3 in the middle of data bit 4.
        cbyte = 8'hC3;
        rx_serial = 1'b0;
        tick(CPB);
        for (int k = 0; k < 4; k++) begin
            rx_serial = cbyte[k];
            tick(CPB);
        end
        rx_serial = cbyte[4];
        tick(HALF);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async_reset_rx_data",       int'(rx_data),       0);
        cmp("async_reset_char_received", int'(char_received), 0);
        cmp("async_reset_framing_error", int'(framing_error), 0);
        cmp("async_reset_overrun_error", int'(overrun_error), 0);
        m_data = 8'h00;
        m_cr   = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
        rx_serial = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        tick(3);

        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom_range(0, 255)),
                       $urandom_range(0, 9) < 8,
                       $urandom_range(0, 4) == 0,
                       $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) pulse_ack();
            tick($urandom_range(0, 6));
        end

        tick(20);
        cmp("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
